des_perm_pipe: RTL and testbench

DES_PERM_PIPE -- requirements
Module: des_perm_pipe

---
 rtl/des_pkg.sv | 34 +++
 rtl/des_perm_core.sv | 16 +
 rtl/des_perm_pipe.sv | 136 +++++++++++++
 tb/tb_des_perm_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared constants for the DES IP / IP^-1 permutation pipe.
// Tables are 1-based DES bit numbers; entry k names the source of output bit k.
package des_pkg;

    localparam int BLK_W = 64;

    typedef enum logic {
        MODE_IP = 1'b0,
        MODE_FP = 1'b1
    } mode_e;

    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int FP_TAB [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

endpackage

// File: rtl/des_perm_core.sv
// Pure wiring: selects DES IP or IP^-1 on a 64-bit block.
// Bit index k corresponds to DES standard bit k+1.
module des_perm_core
    import des_pkg::*;
(
    input  logic [BLK_W-1:0] blk_i,
    input  logic             mode_i,
    output logic [BLK_W-1:0] blk_o
);

    for (genvar k = 0; k < BLK_W; k++) begin : g_bit
        assign blk_o[k] = (mode_i == MODE_FP) ? blk_i[FP_TAB[k]-1]
                                              : blk_i[IP_TAB[k]-1];
    end

endmodule

// File: rtl/des_perm_pipe.sv
// Valid/ready pipeline applying DES IP or IP^-1, tag and mode carried along.
// Define DES_PERM_CHECK_EN to add an inverse-permutation self-check (chk_err).
module des_perm_pipe
    import des_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [BLK_W-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_mode,
    output logic [15:0]      blk_cnt,
    output logic             chk_err
);

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] mode_q;
    logic [BLK_W-1:0]  data_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [BLK_W-1:0]  perm;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;
    logic              in_xfer;
    logic              out_xfer;

    des_perm_core u_core (
        .blk_i  (in_data),
        .mode_i (in_mode),
        .blk_o  (perm)
    );

    // A stage loads when any stage from it to the output is empty or the port drains.
    always_comb begin : p_load
        logic acc;
        acc  = out_ready;
        load = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc     = acc | ~vld_q[i];
            load[i] = acc;
        end
    end

    assign in_ready  = rst_n & ~flush & load[0];
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = rst_n & vld_q[STAGES-1];
    assign out_xfer  = out_valid & out_ready & ~flush;
    assign out_data  = data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign out_mode  = mode_q[STAGES-1];
    assign blk_cnt   = cnt_q;

    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = load[0] ? in_xfer : vld_q[0];
        for (int i = 1; i < STAGES; i++) begin
            if (load[i]) begin
                vld_d[i] = vld_q[i-1];
            end
        end
        cnt_d = out_xfer ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= flush ? '0 : vld_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            data_q[0] <= perm;
            tag_q[0]  <= in_tag;
            mode_q[0] <= in_mode;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (load[i] && vld_q[i-1]) begin
                data_q[i] <= data_q[i-1];
                tag_q[i]  <= tag_q[i-1];
                mode_q[i] <= mode_q[i-1];
            end
        end
    end

`ifdef DES_PERM_CHECK_EN
    logic [BLK_W-1:0] orig_q [STAGES];
    logic [BLK_W-1:0] back;
    logic             err_q;

    // Undo the permutation at the port and compare with the carried input.
    des_perm_core u_chk (
        .blk_i  (out_data),
        .mode_i (~out_mode),
        .blk_o  (back)
    );

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            orig_q[0] <= in_data;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (load[i] && vld_q[i-1]) begin
                orig_q[i] <= orig_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (out_xfer && (back != orig_q[STAGES-1])) begin
            err_q <= 1'b1;
        end
    end

    assign chk_err = err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed bench for des_perm_pipe (STAGES=2, TAG_W=4).
// Expected blocks come from an arithmetic form of the DES IP / IP^-1 tables.
module tb_des_perm_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [63:0] in_data;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_tag;
    logic        out_mode;
    logic [15:0] blk_cnt;
    logic        chk_err;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [63:0] exp_d [$];
    logic [3:0]  exp_t [$];
    logic        exp_m [$];

    des_perm_pipe #(.STAGES(2), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_mode  (out_mode),
        .blk_cnt   (blk_cnt),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    // IP rows start 58,60,62,64,57,59,61,63 and step -8; IP^-1 follows 40,8,48,16.. minus row.
    function automatic logic [63:0] ref_perm(input logic m, input logic [63:0] d);
        logic [63:0] r;
        int src, row, col;
        r = '0;
        for (int k = 0; k < 64; k++) begin
            row = k / 8;
            col = k % 8;
            if (!m) src = ((row < 4) ? 58 + 2 * row : 49 + 2 * row) - 8 * col;
            else    src = (((col % 2) == 0) ? 40 + 4 * col : 4 * col + 4) - row;
            r[k] = d[src-1];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_get(input logic m, input logic [63:0] d, input logic [3:0] t,
                            output logic [63:0] r);
        int n;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_tag   = t;
        tick();
        in_valid = 1'b0;
        #1;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check("send_get_timeout", {63'd0, out_valid}, 64'd1);
        r = out_data;
        tick();
    endtask

    task automatic pop_cmp(input string tag);
        logic [63:0] ed;
        logic [3:0]  et;
        logic        em;
        if (exp_d.size() == 0) begin
            check({tag, "_extra"}, 64'd1, 64'd0);
        end else begin
            ed = exp_d.pop_front();
            et = exp_t.pop_front();
            em = exp_m.pop_front();
            check({tag, "_data"}, out_data, ed);
            check({tag, "_tag"}, {60'd0, out_tag}, {60'd0, et});
            check({tag, "_mode"}, {63'd0, out_mode}, {63'd0, em});
        end
    endtask

    initial begin
        logic [63:0] r;
        logic [63:0] r2;
        logic [63:0] sd [3];
        logic        sm [3];
        int sent, got, cyc, n;
        bit seen;

        sd[0] = 64'h0123_4567_89ab_cdef;
        sd[1] = 64'hfedc_ba98_7654_3210;
        sd[2] = 64'h8000_0000_0000_0001;
        sm[0] = 1'b0;
        sm[1] = 1'b1;
        sm[2] = 1'b0;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
        in_data = '0; in_tag = '0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_blk_cnt", {48'd0, blk_cnt}, 64'd0);
        check("rst_chk_err", {63'd0, chk_err}, 64'd0);

        // bit 57 through IP lands on bit 0 after two edges
        rst_n = 1'b1;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 64'h0200_0000_0000_0000; in_tag = 4'h5;
        #1;
        check("ip_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("ip_lat1_valid", {63'd0, out_valid}, 64'd0);
        tick();
        check("ip_lat2_valid", {63'd0, out_valid}, 64'd1);
        check("ip_bit57_data", out_data, 64'h1);
        check("ip_tag", {60'd0, out_tag}, 64'h5);
        check("ip_mode", {63'd0, out_mode}, 64'd0);
        tick();
        check("ip_cnt_one", {48'd0, blk_cnt}, 64'd1);
        check("ip_drained", {63'd0, out_valid}, 64'd0);

        send_get(1'b1, 64'h1, 4'h6, r);
        check("fp_bit0", r, 64'h0200_0000_0000_0000);
        send_get(1'b0, r, 4'h7, r2);
        check("fp_ip_round", r2, 64'h1);
        send_get(1'b0, 64'h1, 4'h8, r);
        check("ip_bit0_to_39", r, 64'h0000_0080_0000_0000);
        check("cnt_four", {48'd0, blk_cnt}, 64'd4);

        // 100 back-to-back blocks, alternating modes
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sent = 0; got = 0; cyc = 0;
        while (got < 100 && cyc < 400) begin
            if (sent < 100) begin
                in_valid = 1'b1;
                in_mode  = sent[0];
                in_data  = {$urandom, $urandom};
                in_tag   = sent[3:0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                exp_d.push_back(ref_perm(in_mode, in_data));
                exp_t.push_back(in_tag);
                exp_m.push_back(in_mode);
                sent++;
            end
            if (out_valid && out_ready) begin
                pop_cmp("b2b");
                got++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b_count", 64'(got), 64'd100);
        check("b2b_cycles", 64'(cyc), 64'd102);
        check("b2b_blk_cnt", {48'd0, blk_cnt}, 64'd100);

        // stream to the 16-bit wrap point
        n = 65435;
        sent = 0; got = 0; cyc = 0;
        while (got < n && cyc < 70000) begin
            in_valid = (sent < n);
            in_mode  = 1'b0;
            in_data  = 64'(sent);
            #1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) got++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("wrap_ffff", {48'd0, blk_cnt}, 64'hffff);
        send_get(1'b1, 64'h5a5a, 4'h1, r);
        check("wrap_zero", {48'd0, blk_cnt}, 64'h0);

        // output stall with 3 blocks offered
        out_ready = 1'b0;
        exp_d.delete(); exp_t.delete(); exp_m.delete();
        sent = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (sent < 3);
            if (sent < 3) begin
                in_mode = sm[sent];
                in_data = sd[sent];
                in_tag  = 4'(sent + 1);
            end
            #1;
            check("stall_in_ready", {63'd0, in_ready}, (c < 2) ? 64'd1 : 64'd0);
            if (in_valid && in_ready) begin
                exp_d.push_back(ref_perm(in_mode, in_data));
                exp_t.push_back(in_tag);
                exp_m.push_back(in_mode);
                sent++;
            end
            if (c >= 2) begin
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                check("stall_data", out_data, ref_perm(1'b0, 64'h0123_4567_89ab_cdef));
                check("stall_tag", {60'd0, out_tag}, 64'd1);
            end
            tick();
        end
        check("stall_accepted", 64'(sent), 64'd2);
        out_ready = 1'b1;
        got = 0; cyc = 0;
        while (got < 3 && cyc < 20) begin
            in_valid = (sent < 3);
            if (sent < 3) begin
                in_mode = sm[sent];
                in_data = sd[sent];
                in_tag  = 4'(sent + 1);
            end
            #1;
            if (in_valid && in_ready) begin
                exp_d.push_back(ref_perm(in_mode, in_data));
                exp_t.push_back(in_tag);
                exp_m.push_back(in_mode);
                sent++;
            end
            if (out_valid && out_ready) begin
                pop_cmp("stall_out");
                got++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("stall_got3", 64'(got), 64'd3);
        check("stall_cnt", {48'd0, blk_cnt}, 64'd3);

        // reset with two blocks in flight
        in_valid = 1'b1; in_mode = 1'b0; in_data = 64'h1111; in_tag = 4'h2;
        tick();
        in_data = 64'h2222;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        rst_n = 1'b1;
        check("midrst_cnt", {48'd0, blk_cnt}, 64'd0);
        in_valid = 1'b1; in_mode = 1'b1; in_data = 64'hdead_beef_0bad_f00d; in_tag = 4'hc;
        tick();
        in_valid = 1'b0;
        #1;
        check("midrst_lat1", {63'd0, out_valid}, 64'd0);
        tick();
        check("midrst_lat2", {63'd0, out_valid}, 64'd1);
        check("midrst_data", out_data, ref_perm(1'b1, 64'hdead_beef_0bad_f00d));
        check("midrst_tag", {60'd0, out_tag}, 64'hc);
        tick();
        check("midrst_cnt1", {48'd0, blk_cnt}, 64'd1);

        // flush with two blocks in flight, input offered at the same time
        in_valid = 1'b1; in_mode = 1'b0; in_data = 64'h3333; in_tag = 4'h3;
        tick();
        in_data = 64'h4444;
        tick();
        check("pre_flush_valid", {63'd0, out_valid}, 64'd1);
        in_data = 64'h5555;
        flush = 1'b1;
        #1;
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            seen = seen | out_valid;
            tick();
        end
        check("flush_no_output", {63'd0, seen}, 64'd0);
        check("flush_cnt", {48'd0, blk_cnt}, 64'd1);
        check("chk_clean", {63'd0, chk_err}, 64'd0);

`ifdef DES_PERM_CHECK_EN
        in_valid = 1'b1; in_mode = 1'b0; in_data = 64'h0f0f_1234_5678_f0f0; in_tag = 4'h9;
        tick();
        in_valid = 1'b0;
        tick();
        force dut.out_data = ref_perm(1'b0, 64'h0f0f_1234_5678_f0f0) ^ 64'h10;
        tick();
        release dut.out_data;
        #1;
        check("chk_err_set", {63'd0, chk_err}, 64'd1);
        tick();
        tick();
        check("chk_err_sticky", {63'd0, chk_err}, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("chk_err_reset", {63'd0, chk_err}, 64'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
